reaction_timer_core: RTL and testbench

- Upstream stage of the binary-to-BCD converter in the reaction timer.
- Runs the game sequence: idle, random pre-delay, timing of the user's response in milliseconds, result hold.
- Produces the 13-bit millisecond result that feeds the converter's 13-bit binary input, plus status flags for the stimulus LED and display control.

---
 rtl/reaction_timer_core.sv | 143 ++++++++++++++
 tb/tb_reaction_timer_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_core.sv
// Reaction timer game sequencer: idle, random pre-delay, millisecond response
// timing and result hold. The 13-bit count feeds the binary-to-BCD converter.
module reaction_timer_core #(
    parameter int          TICK_DIV     = 100000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [12:0] count,
    output logic        led,
    output logic        busy,
    output logic        done,
    output logic        early,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_TIMING = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [19:0] TICK_MAX   = 20'(TICK_DIV - 1);
    localparam logic [12:0] DELAY_BASE = 13'(MIN_DELAY_MS);
    localparam logic [12:0] COUNT_MAX  = 13'h1FFF;

    state_t      state_r;
    logic [19:0] presc_r;
    logic [15:0] lfsr_r;
    logic [12:0] delay_r;
    logic        tick_s;
    logic [12:0] delay_load_s;

    // Fibonacci LFSR step, taps 16,14,13,11; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign tick_s       = (presc_r == TICK_MAX);
    assign delay_load_s = DELAY_BASE + {2'b00, lfsr_r[10:0]};

    // Free-running LFSR: advances every cycle so the user's start timing picks the delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Game FSM with prescaler, delay counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            presc_r <= 20'd0;
            delay_r <= 13'd0;
            count   <= 13'd0;
            led     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            early   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            // Default prescaler advance; every state entry below overrides it with 0.
            presc_r <= tick_s ? 20'd0 : presc_r + 20'd1;
            case (state_r)
                S_IDLE, S_RESULT: begin
                    if (start) begin
                        state_r <= S_WAIT;
                        presc_r <= 20'd0;
                        delay_r <= delay_load_s;
                        count   <= 13'd0;
                        early   <= 1'b0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        led     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A false start beats a tick landing in the same cycle.
                    if (stop) begin
                        state_r <= S_RESULT;
                        presc_r <= 20'd0;
                        count   <= 13'd0;
                        early   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        led     <= 1'b0;
                    end else if (tick_s) begin
                        if (delay_r == 13'd1) begin
                            state_r <= S_TIMING;
                            presc_r <= 20'd0;
                            delay_r <= 13'd0;
                            count   <= 13'd0;
                            led     <= 1'b1;
                        end else begin
                            delay_r <= delay_r - 13'd1;
                        end
                    end
                end
                S_TIMING: begin
                    // stop freezes count at its pre-edge value, even on a tick.
                    if (stop) begin
                        state_r <= S_RESULT;
                        presc_r <= 20'd0;
                        early   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        led     <= 1'b0;
                    end else if (tick_s) begin
                        if (count == COUNT_MAX) begin
                            state_r <= S_RESULT;
                            presc_r <= 20'd0;
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            led     <= 1'b0;
                        end else begin
                            count <= count + 13'd1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    presc_r <= 20'd0;
                    delay_r <= 13'd0;
                    count   <= 13'd0;
                    led     <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    early   <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Randomized scoreboard bench for reaction_timer_core. Each round is planned
// from the game rules (delay = MIN + LFSR[10:0] ticks, count = ticks elapsed
// before stop), pushed to queues, and a monitor checks outputs every cycle
// and the final result whenever done rises.
module tb_reaction_timer_core;

    localparam int          TD   = 2;
    localparam int          MIN  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [12:0] count;
    logic        led, busy, done, early, timeout;

    reaction_timer_core #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .count(count),
        .led(led), .busy(busy), .done(done), .early(early), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: idle after reset (all zero); kind 1: a round starting at edge 'start'
    typedef struct {
        int kind; int start; int w; int end_e; int fcnt; int fearly; int fto;
    } epoch_t;
    typedef struct { int fcnt; int fearly; int fto; int end_e; } res_t;

    epoch_t epq[$];
    res_t   sbq[$];
    epoch_t cur = '{0, 0, 0, 0, 0, 0, 0};
    int     total = 0;
    int     bad = 0;
    int     last_rst = 0;
    logic   prev_done = 1'b0;

    function automatic void chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: cycle=%0d got=%0d want=%0d", nm, cyc, a, e);
        end
    endfunction

    function automatic logic [15:0] lfsr_at(input int nsteps);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < nsteps; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    always @(negedge clk) begin : monitor_p
        int n, ecnt, eled, ebusy, edone, eearly, eto;
        res_t r;
        n = cyc;
        while (epq.size() > 0 && epq[0].start <= n) cur = epq.pop_front();
        if (n >= 1) begin
            if (cur.kind == 0) begin
                ecnt = 0; eled = 0; ebusy = 0; edone = 0; eearly = 0; eto = 0;
            end else if (n < cur.end_e) begin
                ebusy = 1; edone = 0; eearly = 0; eto = 0;
                if (n >= cur.start + cur.w) begin
                    eled = 1; ecnt = (n - cur.start - cur.w) / TD;
                end else begin
                    eled = 0; ecnt = 0;
                end
            end else begin
                ebusy = 0; eled = 0; edone = 1;
                ecnt = cur.fcnt; eearly = cur.fearly; eto = cur.fto;
            end
            chk("count", int'(count), ecnt);
            chk("led", int'(led), eled);
            chk("busy", int'(busy), ebusy);
            chk("done", int'(done), edone);
            chk("early", int'(early), eearly);
            chk("timeout", int'(timeout), eto);
        end
        if (done === 1'b1 && prev_done === 1'b0) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                r = sbq.pop_front();
                chk("sb_count", int'(count), r.fcnt);
                chk("sb_early", int'(early), r.fearly);
                chk("sb_timeout", int'(timeout), r.fto);
                chk("sb_done_cycle", n, r.end_e);
            end
        end
        prev_done = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: false start at WAIT offset prm (0 random, <0 on the final tick)
    // mode 1: stop prm cycles into TIMING (0 random); mode 2: run to saturation
    // mode 3: reset once count reaches prm
    task automatic run_round(input int mode, input int prm, input bit combo);
        int n, e0, w, k, m, end_e, fcnt, fe, fto, spur, tgt;
        logic [15:0] lf;
        epoch_t ep;
        res_t r;
        n = cyc;
        e0 = n + 1;
        lf = lfsr_at(e0 - 1 - last_rst);
        w = (MIN + int'(lf[10:0])) * TD;
        k = 0; fcnt = 0; fe = 0; fto = 0;
        case (mode)
            0: begin
                k = (prm > 0) ? prm : ((prm < 0) ? w : int'($urandom_range(w, 1)));
                end_e = e0 + k; fe = 1;
            end
            1: begin
                m = (prm > 0) ? prm : int'($urandom_range(600, 1));
                k = w + m; end_e = e0 + k;
                fcnt = (m - 1) / TD;
                if (fcnt > 8191) fcnt = 8191;
            end
            2: begin
                end_e = e0 + w + 8192 * TD; fcnt = 8191; fto = 1;
            end
            default: end_e = 32'h7fffffff;
        endcase
        ep = '{1, e0, w, end_e, fcnt, fe, fto};
        epq.push_back(ep);
        if (mode != 3) begin
            r = '{fcnt, fe, fto, end_e};
            sbq.push_back(r);
        end
        start = 1'b1;
        stop = combo;
        step();
        start = 1'b0;
        stop = 1'b0;
        if (mode <= 1) begin
            spur = e0 + k / 2;
            while (cyc < e0 + k - 1) begin
                start = (cyc == spur && k >= 4);
                step();
            end
            start = 1'b0;
            stop = 1'b1;
            step();
            stop = 1'b0;
        end else if (mode == 2) begin
            while (cyc < end_e) step();
        end else begin
            tgt = e0 + w + prm * TD;
            while (cyc < tgt) step();
            reset = 1'b1;
            ep = '{0, cyc + 1, 0, 0, 0, 0, 0};
            epq.push_back(ep);
            last_rst = cyc + 1;
            step();
            reset = 1'b0;
            stop = 1'b1;
            step();
            stop = 1'b0;
            repeat (30) step();
        end
        if (mode <= 2) repeat ($urandom_range(140, 100)) step();
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        step();
        last_rst = cyc;
        reset = 1'b0;
        repeat (5) step();
        run_round(1, 38 * TD, 1'b0);
        run_round(0, 2 * TD, 1'b0);
        run_round(1, 0, 1'b1);
        run_round(0, -1, 1'b0);
        run_round(0, 1, 1'b0);
        run_round(1, 1, 1'b0);
        run_round(1, 5 * TD, 1'b0);
        for (int i = 0; i < 4; i++) run_round(int'($urandom_range(1, 0)), 0, 1'($urandom_range(1, 0)));
        run_round(2, 0, 1'b0);
        run_round(3, 500, 1'b0);
        run_round(0, 0, 1'b1);
        repeat (10) step();
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
